// File: rtl/ap_hs_pkg.sv
// ap_hs_pkg
//   Shared definitions for the ap_ctrl_hs job master: FSM state encoding
//   and default widths/limits used by ap_hs_job_master and ap_hs_watchdog.
package ap_hs_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,  // waiting for a job on the command port
    ST_START = 2'd1,  // ap_start high, waiting for ap_ready
    ST_WAIT  = 2'd2,  // started, waiting for ap_done
    ST_RESP  = 2'd3   // result held on the response port
  } state_t;

  localparam int DATA_W_DEF  = 32;
  localparam int TO_W_DEF    = 16;
  localparam int TIMEOUT_DEF = 1000;
  localparam int JOB_CNT_W   = 16;

endpackage

// File: rtl/ap_hs_watchdog.sv
// ap_hs_watchdog
//   Cycle counter that aborts a job which stays too long in START+WAIT.
//   The count is cleared when a job is accepted and advances on every
//   enabled cycle; 'expired' flags the enabled cycle in which the count
//   sits at TIMEOUT-1, i.e. the TIMEOUT-th cycle of the job.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   clr       : restart the count at zero (job acceptance)
//   en        : count this cycle (job in START or WAIT)
//   expired   : last allowed cycle of the job
module ap_hs_watchdog
  import ap_hs_pkg::*;
#(
  parameter int TO_W    = TO_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  // The job leaves START/WAIT on expiry, so the count never passes LAST.
  assign expired = en && (count == LAST);

endmodule

// File: rtl/ap_hs_job_master.sv
// ap_hs_job_master
//   Host-side initiator for an ap_ctrl_hs HLS core. Takes a job (s, e) on
//   the command port, holds the arguments on core_s/core_e, pulses the core
//   through ap_start/ap_ready, waits for ap_done and returns ap_return on
//   the response port. A watchdog turns a job that never finishes into a
//   timeout response (rsp_data=0, rsp_timeout=1).
// Ports:
//   ap_clk, ap_rst            : clock, asynchronous active-high reset
//   cmd_valid/cmd_ready       : job request handshake, cmd_s/cmd_e arguments
//   core_ap_*                 : ap_ctrl_hs block-level handshake to the core
//   core_s/core_e             : registered arguments, held until next job
//   core_ap_return            : core result
//   rsp_valid/rsp_ready       : response handshake, rsp_data/rsp_timeout
//   busy                      : a job is in flight or its response is held
//   job_count                 : completed response handshakes (wraps)
//
// Handshakes: both ports use strict valid/ready. A transfer happens on a
// rising edge where valid and ready are both high. cmd_ready is a pure
// function of state and core_ap_idle and never looks at cmd_valid.
// rsp_valid, once high, stays high with rsp_data/rsp_timeout stable until
// the transfer; it never depends on rsp_ready.
module ap_hs_job_master
  import ap_hs_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TO_W    = TO_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [DATA_W-1:0]    cmd_s,
  input  logic [DATA_W-1:0]    cmd_e,
  output logic                 core_ap_start,
  input  logic                 core_ap_done,
  input  logic                 core_ap_idle,
  input  logic                 core_ap_ready,
  output logic [DATA_W-1:0]    core_s,
  output logic [DATA_W-1:0]    core_e,
  input  logic [DATA_W-1:0]    core_ap_return,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DATA_W-1:0]    rsp_data,
  output logic                 rsp_timeout,
  output logic                 busy,
  output logic [JOB_CNT_W-1:0] job_count
);

  state_t state_q;
  state_t state_d;

  logic accept;      // command transfer this cycle
  logic cap_return;  // normal completion: capture ap_return
  logic cap_abort;   // watchdog expiry without done
  logic rsp_fire;    // response transfer this cycle
  logic wd_en;
  logic wd_expired;

  assign cmd_ready = (state_q == ST_IDLE) && core_ap_idle;
  assign busy      = (state_q != ST_IDLE);
  assign wd_en     = (state_q == ST_START) || (state_q == ST_WAIT);

  ap_hs_watchdog #(
    .TO_W    (TO_W),
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (ap_clk),
    .rst     (ap_rst),
    .clr     (accept),
    .en      (wd_en),
    .expired (wd_expired)
  );

  // Next-state logic. A done that coincides with watchdog expiry is a
  // normal completion, so done is tested before expiry in both states.
  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    cap_return = 1'b0;
    cap_abort  = 1'b0;
    rsp_fire   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          accept  = 1'b1;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (core_ap_ready && core_ap_done) begin
          cap_return = 1'b1;
          state_d    = ST_RESP;
        end else if (wd_expired) begin
          cap_abort = 1'b1;
          state_d   = ST_RESP;
        end else if (core_ap_ready) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (core_ap_done) begin
          cap_return = 1'b1;
          state_d    = ST_RESP;
        end else if (wd_expired) begin
          cap_abort = 1'b1;
          state_d   = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_fire = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // core_ap_start and rsp_valid are registered decodes of the next state so
  // that they are glitch-free and track the FSM exactly one edge later.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      core_ap_start <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_data      <= '0;
      rsp_timeout   <= 1'b0;
      core_s        <= '0;
      core_e        <= '0;
      job_count     <= '0;
    end else begin
      core_ap_start <= (state_d == ST_START);
      rsp_valid     <= (state_d == ST_RESP);
      if (accept) begin
        core_s <= cmd_s;
        core_e <= cmd_e;
      end
      // Captures only happen on the START/WAIT exits, so a stray done seen
      // in IDLE or RESP leaves the held response untouched.
      if (cap_return) begin
        rsp_data    <= core_ap_return;
        rsp_timeout <= 1'b0;
      end else if (cap_abort) begin
        rsp_data    <= '0;
        rsp_timeout <= 1'b1;
      end
      if (rsp_fire) begin
        job_count <= job_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ap_hs_job_master.sv
`timescale 1ns/1ps
module tb_ap_hs_job_master;
  import ap_hs_pkg::*;

  localparam int DW = 32;
  localparam int TO = 20;

  // ---------------- clock / reset ----------------
  logic ap_clk = 1'b0;
  logic ap_rst = 1'b0;
  always #5 ap_clk = ~ap_clk;

  logic          cmd_valid, cmd_ready;
  logic [DW-1:0] cmd_s, cmd_e;
  logic          core_ap_start;
  logic          core_ap_done = 1'b0, core_ap_idle = 1'b1, core_ap_ready = 1'b0;
  logic [DW-1:0] core_s, core_e;
  logic [DW-1:0] core_ap_return = '0;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          rsp_timeout, busy;
  logic [15:0]   job_count;

  ap_hs_job_master #(.DATA_W(DW), .TO_W(16), .TIMEOUT(TO)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_s(cmd_s), .cmd_e(cmd_e),
    .core_ap_start(core_ap_start), .core_ap_done(core_ap_done),
    .core_ap_idle(core_ap_idle), .core_ap_ready(core_ap_ready),
    .core_s(core_s), .core_e(core_e), .core_ap_return(core_ap_return),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_timeout(rsp_timeout), .busy(busy), .job_count(job_count)
  );

  int unsigned cyc = 0;  // number of rising edges so far
  always @(posedge ap_clk) cyc++;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] even_sum(input logic [31:0] s, input logic [31:0] e);
    logic [31:0] acc = 0;
    for (longint v = longint'(s); v <= longint'(e); v++)
      if (v % 2 == 0) acc += 32'(v);
    return acc;
  endfunction

  // ---------------- behavioural core (even-sum HLS core) ----------------
  // Raises ap_ready job_rlat cycles into ap_start, then ap_done job_dlat
  // cycles after ready (same cycle when job_dlat==0). Hang jobs never finish
  // unless stray_req forces a late done with return 0x55.
  int  job_rlat = 0, job_dlat = 0;
  bit  job_hang = 0, idle_en = 1, stray_req = 0;
  bit  running = 0, run_hang = 0;
  int  start_seen = 0, done_in = 0;
  logic [31:0] result = 0;

  always @(posedge ap_clk) begin
    #2;
    core_ap_ready = 1'b0;
    core_ap_done  = 1'b0;
    if (ap_rst) begin
      running = 0; start_seen = 0;
    end else if (stray_req) begin
      core_ap_done = 1'b1; core_ap_return = 32'h55; running = 0; stray_req = 0;
    end else if (running) begin
      done_in--;
      if (done_in <= 0 && !run_hang) begin
        core_ap_done = 1'b1; core_ap_return = result; running = 0;
      end
    end else if (core_ap_start) begin
      if (start_seen >= job_rlat) begin
        core_ap_ready = 1'b1;
        result = even_sum(core_s, core_e);
        start_seen = 0;
        if (job_dlat == 0) begin
          core_ap_done = 1'b1; core_ap_return = result;
        end else begin
          running = 1; done_in = job_dlat; run_hang = job_hang;
        end
      end else begin
        start_seen++;
      end
    end
    core_ap_idle = !running && idle_en;
  end

  int start_hi = 0;  // start-high cycles since the last do_accept
  always @(negedge ap_clk) if (!ap_rst && core_ap_start) start_hi++;

  // ---------------- reference model + per-cycle compare ----------------
  // Job timeline: accepted at edge A; start high after edges A..A+rlat;
  // done sampled at A+1+rlat+dlat; the watchdog fires at A+TO unless done
  // arrives no later than that edge. Response held until rsp_ready.
  bit          chk_en = 0;
  bit          in_job = 0;
  int unsigned acc_edge = 0, rsp_edge = 0, start_last = 0;
  logic [31:0] exp_q[$];
  bit          exp_to_q[$];
  logic [31:0] exp_s = 0, exp_e = 0;
  logic [15:0] exp_jobs = 0;

  always @(negedge ap_clk) begin
    bit          v_exp;
    bit          st_exp;
    bit          to_exp;
    int unsigned done_edge;
    if (ap_rst) begin
      in_job = 0; exp_q.delete(); exp_to_q.delete();
      exp_s = 0; exp_e = 0; exp_jobs = 0;
    end else if (chk_en) begin
      v_exp  = in_job && (cyc >= rsp_edge);
      st_exp = in_job && (cyc >= acc_edge) && (cyc <= start_last);
      chk("busy", busy, in_job);
      chk("core_ap_start", core_ap_start, st_exp);
      chk("rsp_valid", rsp_valid, v_exp);
      chk("cmd_ready", cmd_ready, !in_job && core_ap_idle);
      chk("job_count", job_count, exp_jobs);
      chk("core_s", core_s, exp_s);
      chk("core_e", core_e, exp_e);
      if (v_exp) begin
        chk("rsp_data", rsp_data, exp_q[0]);
        chk("rsp_timeout", rsp_timeout, exp_to_q[0]);
      end
      // predict the transfer at the coming edge
      if (!in_job && cmd_valid && core_ap_idle) begin
        in_job    = 1;
        acc_edge  = cyc + 1;
        done_edge = acc_edge + 1 + job_rlat + job_dlat;
        to_exp    = job_hang || (done_edge > acc_edge + TO);
        rsp_edge  = to_exp ? acc_edge + TO : done_edge;
        start_last = (acc_edge + job_rlat < rsp_edge - 1) ? acc_edge + job_rlat : rsp_edge - 1;
        exp_q.push_back(to_exp ? 32'd0 : even_sum(cmd_s, cmd_e));
        exp_to_q.push_back(to_exp);
        exp_s = cmd_s; exp_e = cmd_e;
      end else if (v_exp && rsp_ready) begin
        in_job = 0;
        exp_jobs++;
        void'(exp_q.pop_front());
        void'(exp_to_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge ap_clk); #1;
  endtask

  task automatic do_accept(input logic [31:0] s, input logic [31:0] e, input int rlat,
                           input int dlat, input bit hang, output int unsigned acc);
    int n = 0;
    job_rlat = rlat; job_dlat = dlat; job_hang = hang; start_hi = 0;
    cmd_s = s; cmd_e = e; cmd_valid = 1'b1;
    @(negedge ap_clk);
    while (!cmd_ready && n < 100) begin
      @(negedge ap_clk); n++;
    end
    chk("accept_ready", cmd_ready, 1);
    acc = cyc + 1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output logic [31:0] d, output logic to, output int unsigned vedge);
    int n = 0;
    @(negedge ap_clk);
    while (!rsp_valid && n < 200) begin
      @(negedge ap_clk); n++;
    end
    chk("rsp_arrive", rsp_valid, 1);
    vedge = cyc; d = rsp_data; to = rsp_timeout;
  endtask

  task automatic release_rsp(input int hold);
    tick();
    repeat (hold) tick();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] d;
    logic        to;
    int unsigned acc, ve, hs, t0;
    logic [31:0] rs, re;
    int          rl, dl;

    cmd_valid = 0; cmd_s = 0; cmd_e = 0; rsp_ready = 0;
    #1 ap_rst = 1'b1;
    #1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_start", core_ap_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_job_count", job_count, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_core_s", core_s, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    repeat (2) @(posedge ap_clk);
    #3 ap_rst = 1'b0;
    tick();
    chk_en = 1;

    // s=2,e=10 -> 30, ready after 2 extra start cycles, done 5 after ready
    do_accept(2, 10, 2, 5, 0, acc);
    wait_rsp(d, to, ve);
    chk("job1_data", d, 30);
    chk("job1_to", to, 0);
    chk("job1_latency", ve - acc, 8);
    chk("job1_start_cycles", start_hi, 3);
    release_rsp(0);
    chk("job1_count", job_count, 1);

    // ready and done with the first start-high cycle
    do_accept(3, 3, 0, 0, 0, acc);
    wait_rsp(d, to, ve);
    chk("same_cycle_data", d, 0);
    chk("same_cycle_to", to, 0);
    chk("same_cycle_start_cycles", start_hi, 1);
    chk("same_cycle_latency", ve - acc, 1);
    release_rsp(0);

    // core never finishes -> timeout; late done must not disturb the response
    do_accept(5, 9, 0, 1, 1, acc);
    wait_rsp(d, to, ve);
    chk("timeout_to", to, 1);
    chk("timeout_data", d, 0);
    chk("timeout_latency", ve - acc, TO);
    stray_req = 1;
    repeat (4) tick();
    chk("stray_data", rsp_data, 0);
    chk("stray_to", rsp_timeout, 1);
    chk("stray_valid", rsp_valid, 1);
    release_rsp(0);
    repeat (5) tick();
    chk("no_extra_rsp", rsp_valid, 0);
    chk("timeout_count", job_count, 3);

    // response held 10 cycles with a new command waiting
    do_accept(1, 6, 1, 3, 0, acc);
    wait_rsp(d, to, ve);
    chk("hold_first", d, 12);
    tick();
    job_rlat = 0; job_dlat = 2; job_hang = 0;
    cmd_s = 2; cmd_e = 8; cmd_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("hold_data", rsp_data, 12);
      chk("hold_cmd_ready", cmd_ready, 0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    hs = cyc;
    do_accept(2, 8, 0, 2, 0, acc);
    chk("one_idle_cycle", acc - hs, 1);
    wait_rsp(d, to, ve);
    chk("hold_second", d, 20);
    release_rsp(1);

    // core not idle: command must wait
    idle_en = 0;
    tick();
    job_rlat = 0; job_dlat = 1; job_hang = 0;
    cmd_s = 4; cmd_e = 4; cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_low_cmd_ready", cmd_ready, 0);
      chk("idle_low_busy", busy, 0);
    end
    idle_en = 1;
    t0 = cyc;
    do_accept(4, 4, 0, 1, 0, acc);
    chk("idle_high_accept", acc, t0 + 1);
    wait_rsp(d, to, ve);
    chk("idle_job_data", d, 4);
    release_rsp(0);

    // done exactly on the watchdog's last cycle wins; one later times out
    do_accept(2, 4, 0, TO - 1, 0, acc);
    wait_rsp(d, to, ve);
    chk("edge_done_to", to, 0);
    chk("edge_done_data", d, 6);
    chk("edge_done_latency", ve - acc, TO);
    release_rsp(0);
    do_accept(2, 4, 0, TO, 0, acc);
    wait_rsp(d, to, ve);
    chk("edge_late_to", to, 1);
    chk("edge_late_data", d, 0);
    release_rsp(2);

    // randomized jobs, checked cycle by cycle by the model
    for (int j = 0; j < 24; j++) begin
      rs = $urandom_range(0, 50);
      re = $urandom_range(0, 60);
      rl = $urandom_range(0, 3);
      dl = ($urandom_range(0, 4) == 0) ? $urandom_range(15, 24) : $urandom_range(0, 6);
      repeat ($urandom_range(0, 3)) tick();
      do_accept(rs, re, rl, dl, 0, acc);
      wait_rsp(d, to, ve);
      release_rsp($urandom_range(0, 4));
    end

    // asynchronous reset in the middle of WAIT
    do_accept(1, 9, 1, 8, 0, acc);
    repeat (4) tick();
    @(negedge ap_clk);
    chk("pre_reset_busy", busy, 1);
    #2 ap_rst = 1'b1;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_start", core_ap_start, 0);
    chk("async_rst_rsp_valid", rsp_valid, 0);
    chk("async_rst_job_count", job_count, 0);
    repeat (2) @(posedge ap_clk);
    #3 ap_rst = 1'b0;
    tick();
    do_accept(4, 8, 0, 5, 0, acc);
    wait_rsp(d, to, ve);
    chk("post_reset_data", d, 18);
    chk("post_reset_to", to, 0);
    release_rsp(0);
    chk("post_reset_count", job_count, 1);
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    n_err++;
    $display("FAIL sim_time_limit: got no end of test, expected finish before 500us");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
